// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receive capture block.
package uart_rx_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } rx_state_t;

    localparam logic [7:0] EOL_CHAR = 8'h0A;
    localparam int         CNT_W    = 16;

endpackage

// File: rtl/uart_rx_fifo.sv
// First-word fall-through byte FIFO; head byte is visible while valid is high.
module uart_rx_fifo #(
    parameter int DEPTH = 16
) (
    input  logic       clk,
    input  logic       srst,
    input  logic       wr_en,
    input  logic [7:0] wr_data,
    output logic       wr_ok,
    output logic       full,
    input  logic       rd_en,
    output logic [7:0] rd_data,
    output logic       valid
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [CW-1:0] count_reg;
    logic          pop;
    logic          push;

    assign valid = (count_reg != '0);
    assign full  = (count_reg == DEPTH_C);
    assign pop   = rd_en && valid;
    // A full FIFO still accepts a byte when the head leaves in the same cycle.
    assign push  = wr_en && (!full || pop);
    assign wr_ok = push;

    // Head read is combinational so a fresh byte falls through immediately.
    assign rd_data = valid ? mem[rd_ptr_reg] : 8'h00;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + CW'(1);
                2'b01:   count_reg <= count_reg - CW'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_capture.sv
// 8N1 UART receiver feeding a fall-through byte FIFO with framing-error,
// overflow and received-byte reporting.
module uart_rx_capture
    import uart_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 32,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_i,
    output logic [7:0]  data_o,
    output logic        valid_o,
    input  logic        ready_i,
    output logic        eol_o,
    output logic        frame_err_o,
    output logic        overflow_o,
    output logic [15:0] byte_cnt_o
);

    localparam logic [CNT_W-1:0] HALF_BIT = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_BIT = CNT_W'(CLKS_PER_BIT - 1);

    rx_state_t        state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [2:0]       bit_idx_reg, bit_idx_next;
    logic [7:0]       shift_reg, shift_next;
    logic             rx_meta_reg;
    logic             rx_s_reg;
    logic [1:0]       settle_reg;
    logic             armed_reg;
    logic             byte_wr;
    logic             frame_err_next;
    logic             frame_err_reg;
    logic             overflow_reg;
    logic [15:0]      byte_cnt_reg;
    logic             fifo_wr_ok;
    logic             fifo_full;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_reg <= 1'b1;
            rx_s_reg    <= 1'b1;
        end else begin
            rx_meta_reg <= rx_i;
            rx_s_reg    <= rx_meta_reg;
        end
    end

    // After reset the synchronizer holds forced ones; wait until it carries the
    // real line and that line is idle before a falling edge may start a frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            settle_reg <= 2'b00;
            armed_reg  <= 1'b0;
        end else begin
            settle_reg <= {settle_reg[0], 1'b1};
            if (settle_reg[1] && rx_s_reg) begin
                armed_reg <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            bit_idx_reg <= '0;
            shift_reg   <= '0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            bit_idx_reg <= bit_idx_next;
            shift_reg   <= shift_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        bit_idx_next   = bit_idx_reg;
        shift_next     = shift_reg;
        byte_wr        = 1'b0;
        frame_err_next = 1'b0;
        case (state_reg)
            IDLE: begin
                if (armed_reg && !rx_s_reg) begin
                    cnt_next   = HALF_BIT;
                    state_next = START;
                end
            end
            START: begin
                if (cnt_reg == '0) begin
                    if (!rx_s_reg) begin
                        state_next   = DATA;
                        cnt_next     = FULL_BIT;
                        bit_idx_next = 3'd0;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    cnt_next = cnt_reg - CNT_W'(1);
                end
            end
            DATA: begin
                if (cnt_reg == '0) begin
                    shift_next = {rx_s_reg, shift_reg[7:1]};
                    cnt_next   = FULL_BIT;
                    if (bit_idx_reg == 3'd7) begin
                        state_next = STOP;
                    end else begin
                        bit_idx_next = bit_idx_reg + 3'd1;
                    end
                end else begin
                    cnt_next = cnt_reg - CNT_W'(1);
                end
            end
            STOP: begin
                if (cnt_reg == '0) begin
                    if (rx_s_reg) begin
                        byte_wr    = 1'b1;
                        state_next = IDLE;
                    end else begin
                        frame_err_next = 1'b1;
                        state_next     = BREAK;
                    end
                end else begin
                    cnt_next = cnt_reg - CNT_W'(1);
                end
            end
            BREAK: begin
                if (rx_s_reg) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    uart_rx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .srst    (rst),
        .wr_en   (byte_wr),
        .wr_data (shift_reg),
        .wr_ok   (fifo_wr_ok),
        .full    (fifo_full),
        .rd_en   (ready_i),
        .rd_data (data_o),
        .valid   (valid_o)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            frame_err_reg <= 1'b0;
            overflow_reg  <= 1'b0;
            byte_cnt_reg  <= '0;
        end else begin
            frame_err_reg <= frame_err_next;
            if (byte_wr && !fifo_wr_ok) begin
                overflow_reg <= 1'b1;
            end
            if (fifo_wr_ok) begin
                byte_cnt_reg <= byte_cnt_reg + 16'd1;
            end
        end
    end

    assign eol_o       = valid_o && (data_o == EOL_CHAR);
    assign frame_err_o = frame_err_reg;
    assign overflow_o  = overflow_reg;
    assign byte_cnt_o  = byte_cnt_reg;

    // fifo_full is only needed inside the FIFO's own accept decision.
    logic unused_full;
    assign unused_full = fifo_full;

endmodule

// File: doc/uart_rx_capture.md
UART_RX_CAPTURE -- requirements
Module: uart_rx_capture

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 32, clock cycles per UART bit (100 MHz / 3.125 Mbaud); legal range 8..65535.
REQ-002 SHALL have parameter FIFO_DEPTH, default 16, byte FIFO entries; power of two, 2..256.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst  input  1  reset; one clock; reset is synchronous and active-high.
REQ-005 SHALL have port rx_i  input  1  asynchronous UART line from the DUT uart_tx pad, idle high, 8N1.
REQ-006 SHALL have port data_o  output  8  head-of-FIFO byte, valid only while valid_o=1.
REQ-007 SHALL have port valid_o  output  1  FIFO not empty.
REQ-008 SHALL have port ready_i  input  1  consumer accepts data_o when valid_o&ready_i.
REQ-009 SHALL have port eol_o  output  1  data_o==8'h0A, qualified by valid_o.
REQ-010 SHALL have port frame_err_o  output  1  one-cycle pulse per frame whose stop bit samples 0.
REQ-011 SHALL have port overflow_o  output  1  sticky; set when a good byte is dropped because the FIFO is full.
REQ-012 SHALL have port byte_cnt_o  output  16  count of bytes written to the FIFO, wraps 16'hFFFF->0.

Function
REQ-013 SHALL pass rx_i through a two-flop synchronizer; all decisions use the second flop (rx_s).
REQ-014 SHALL implement FSM states IDLE, START, DATA, STOP, BREAK.
REQ-015 IDLE: on rx_s=0, load the bit counter with CLKS_PER_BIT/2-1 and go to START.
REQ-016 START: at counter 0, rx_s=0 -> DATA, counter reloads CLKS_PER_BIT-1; rx_s=1 -> IDLE (glitch, no error).
REQ-017 DATA: sample rx_s at each counter 0, shift in LSB first; after the 8th sample go to STOP with counter CLKS_PER_BIT-1.
REQ-018 STOP: at counter 0, rx_s=1 -> write the byte to the FIFO, then IDLE; rx_s=0 -> pulse frame_err_o, discard the byte, go to BREAK.
REQ-019 BREAK: remain until rx_s=1, then go to IDLE; no frame starts while in BREAK.
REQ-020 A written byte SHALL appear on data_o/valid_o the cycle after the stop-bit sample cycle when the FIFO was empty (first-word fall-through).
REQ-021 A FIFO write SHALL succeed when not full, or when full with a pop in the same cycle; otherwise drop the byte, set overflow_o, and leave byte_cnt_o unchanged.
REQ-022 A pop SHALL occur iff valid_o&ready_i; ready_i while empty has no effect.
REQ-023 Simultaneous write and pop SHALL keep the occupancy constant; pointers wrap modulo FIFO_DEPTH.
REQ-024 byte_cnt_o SHALL increment by 1 on each successful FIFO write only.

Reset
REQ-025 rst=1 SHALL force state IDLE, synchronizer flops to 1, FIFO empty, valid_o=0, data_o=0, eol_o=0, frame_err_o=0, overflow_o=0, byte_cnt_o=0.
REQ-026 rst asserted mid-frame SHALL abandon the frame with no FIFO write and no error pulse; after release a frame is recognised only on a new falling edge.

Structure
REQ-027 Package uart_rx_pkg SHALL hold the FSM state enum and the EOL_CHAR constant 8'h0A.
REQ-028 The FIFO SHALL be a sub-module uart_rx_fifo (parameter DEPTH, width 8, synchronous active-high reset, fall-through).

Verification
REQ-029 Send 8'h65 at CLKS_PER_BIT=32 -> valid_o=1 and data_o=8'h65 the cycle after the stop sample; byte_cnt_o=1.
REQ-030 Send "OK\n" with ready_i=1 -> three pops 8'h4F, 8'h4B, 8'h0A; eol_o=1 only with 8'h0A.
REQ-031 Drive a 10-cycle low glitch on rx_i -> no FIFO write, no frame_err_o, FSM returns to IDLE.
REQ-032 Send 8'h55 with stop bit held 0 for 3 bit times -> one frame_err_o pulse, FIFO empty, the next good frame 8'hA5 is received correctly.
REQ-033 With ready_i=0 send 17 bytes at FIFO_DEPTH=16 -> 16 bytes retained in order, overflow_o=1, byte_cnt_o=16; raise ready_i -> 16 bytes drain, overflow_o stays 1.
REQ-034 Assert rst during DATA of byte 8'hC3, release it, then send 8'h3C -> only 8'h3C is received, frame_err_o never pulses.
